// File: rtl/alu_result_stage_if.sv
// ALU result handshake bundle: producer-side capture inputs, consumer-side head-entry outputs.
// master drives the upstream/downstream controls; slave is the result stage itself.
interface alu_result_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] resultofand;
  logic [WIDTH-1:0] resultofor;
  logic [WIDTH-1:0] resultofadd;
  logic [WIDTH-1:0] resultofsub;
  logic [WIDTH-1:0] dataout1;
  logic [WIDTH-1:0] dataout2;
  logic [4:0]       dest_reg;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic [4:0]       out_dest;
  logic             out_illegal;

  modport master (
    output in_valid, alu_op, resultofand, resultofor, resultofadd, resultofsub,
           dataout1, dataout2, dest_reg, flush, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_dest, out_illegal
  );

  modport slave (
    input  in_valid, alu_op, resultofand, resultofor, resultofadd, resultofsub,
           dataout1, dataout2, dest_reg, flush, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_dest, out_illegal
  );
endinterface

// File: rtl/alu_result_stage.sv
// Two-entry result buffer selecting the ALU result at capture; 1 cycle accept-to-out_valid.
// in_ready/out_valid come from registered state only, so out_ready never reaches in_ready.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  alu_result_stage_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
    logic [4:0]       dest;
  } entry_t;

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  state_t count_q, count_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  entry_t new_entry;
  logic   rdy_en_q;
  logic   push;
  logic   pop;

  // zero/illegal are frozen into the entry so later input changes cannot disturb them
  always_comb begin
    new_entry = '0;
    case (bus.alu_op)
      3'b000:  new_entry.result = bus.resultofand;
      3'b001:  new_entry.result = bus.resultofor;
      3'b010:  new_entry.result = bus.resultofadd;
      3'b110:  new_entry.result = bus.resultofsub;
      3'b111:  new_entry.result = {{(WIDTH-1){1'b0}},
                                   ($signed(bus.dataout1) < $signed(bus.dataout2))};
      default: new_entry.illegal = 1'b1;
    endcase
    new_entry.zero = (new_entry.result == '0);
    new_entry.dest = bus.dest_reg;
  end

  // rdy_en_q keeps in_ready low through reset and for the edge that releases it
  assign bus.in_ready  = rdy_en_q && (2'(count_q) != FULL_CNT);
  assign bus.out_valid = (count_q != EMPTY);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      EMPTY: begin
        if (push) begin
          head_d  = new_entry;
          count_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          tail_d  = new_entry;
          count_d = TWO;
        end else if (pop) begin
          count_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = ONE;
        end
      end
      default: count_d = EMPTY;
    endcase
    if (bus.flush) begin
      count_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= EMPTY;
      head_q   <= '0;
      tail_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign bus.out_result  = bus.out_valid ? head_q.result  : '0;
  assign bus.out_zero    = bus.out_valid ? head_q.zero    : 1'b0;
  assign bus.out_dest    = bus.out_valid ? head_q.dest    : 5'd0;
  assign bus.out_illegal = bus.out_valid ? head_q.illegal : 1'b0;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed corner steps plus random traffic against a queue model.
module tb_alu_result_stage;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] result;
    logic         zero;
    logic         illegal;
    logic [4:0]   dest;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  alu_result_stage_if #(.WIDTH(W)) bus ();

  alu_result_stage #(.WIDTH(W), .DEPTH(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t model_q[$];
  bit   model_rdy_en = 1'b0;
  logic [2:0] legal_ops [5] = '{3'd0, 3'd1, 3'd2, 3'd6, 3'd7};

  // what the entry captured from the current inputs must look like
  function automatic exp_t expect_entry();
    exp_t e;
    e.result  = '0;
    e.illegal = 1'b0;
    e.dest    = bus.dest_reg;
    case (bus.alu_op)
      3'd0: e.result = bus.resultofand;
      3'd1: e.result = bus.resultofor;
      3'd2: e.result = bus.resultofadd;
      3'd6: e.result = bus.resultofsub;
      3'd7: if (signed'(bus.dataout1) < signed'(bus.dataout2)) e.result[0] = 1'b1;
      default: e.illegal = 1'b1;
    endcase
    e.zero = (e.result == '0);
    return e;
  endfunction

  task automatic check1(input string tag, input logic got, input logic want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, got, want);
    end
  endtask

  task automatic checkw(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    exp_t h = '{default: '0};
    bit   v = (model_q.size() != 0);
    if (v) h = model_q[0];
    check1({tag, ".out_valid"},   bus.out_valid,   v);
    check1({tag, ".in_ready"},    bus.in_ready,    model_rdy_en && (model_q.size() < 2));
    checkw({tag, ".out_result"},  bus.out_result,  h.result);
    check1({tag, ".out_zero"},    bus.out_zero,    h.zero);
    check1({tag, ".out_illegal"}, bus.out_illegal, h.illegal);
    checkw({tag, ".out_dest"},    W'(bus.out_dest), W'(h.dest));
  endtask

  // one clock: predict the edge from inputs held since the last falling edge, then check
  task automatic cycle(input string tag);
    bit   acc, pop, fl, rs;
    exp_t e;
    acc = bus.in_valid && model_rdy_en && (model_q.size() < 2);
    pop = (model_q.size() != 0) && bus.out_ready;
    fl  = bus.flush;
    rs  = rst_n;
    e   = expect_entry();
    @(posedge clk);
    if (!rs) begin
      model_q.delete();
      model_rdy_en = 1'b0;
    end else begin
      if (fl) begin
        model_q.delete();
      end else begin
        if (pop) void'(model_q.pop_front());
        if (acc) model_q.push_back(e);
      end
      model_rdy_en = 1'b1;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic rand_data();
    bus.resultofand = ($urandom_range(0, 7) == 0) ? '0 : $urandom();
    bus.resultofor  = $urandom();
    bus.resultofadd = ($urandom_range(0, 7) == 0) ? '0 : $urandom();
    bus.resultofsub = $urandom();
    bus.dataout1    = $urandom();
    bus.dataout2    = $urandom();
    bus.dest_reg    = 5'($urandom());
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.alu_op   = 3'd0;
    bus.flush    = 1'b0;
    bus.out_ready = 1'b0;
    rand_data();

    // reset asserted before any clock edge
    #1 rst_n = 1'b0;
    #1 check_all("reset_async");
    bus.in_valid = 1'b1;
    bus.alu_op   = 3'd2;
    cycle("in_reset_a");
    cycle("in_reset_b");
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    cycle("rst_release");
    check1("ready_after_release", bus.in_ready, 1'b1);

    // AND capture
    rand_data();
    bus.alu_op = 3'd0; bus.resultofand = 32'h0000_00F0; bus.dest_reg = 5'd5;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    cycle("and");
    checkw("and_result", bus.out_result, 32'h0000_00F0);
    checkw("and_dest", W'(bus.out_dest), 32'd5);
    check1("and_zero", bus.out_zero, 1'b0);
    bus.in_valid = 1'b0;
    cycle("and_drain");

    // SLT signed compare, then swapped operands back-to-back
    bus.alu_op = 3'd7; bus.dataout1 = 32'hFFFF_FFFF; bus.dataout2 = 32'h0000_0001;
    bus.in_valid = 1'b1;
    cycle("slt");
    checkw("slt_lt", bus.out_result, 32'h0000_0001);
    bus.dataout1 = 32'h0000_0001; bus.dataout2 = 32'hFFFF_FFFF;
    cycle("slt_swap");
    checkw("slt_ge", bus.out_result, 32'h0000_0000);
    check1("slt_ge_zero", bus.out_zero, 1'b1);
    bus.in_valid = 1'b0;
    cycle("slt_drain");

    // backpressure: fill two, hold, then drain in order
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.alu_op = 3'd2;
    rand_data(); bus.resultofadd = 32'h11;
    cycle("bp_a");
    rand_data(); bus.resultofadd = 32'h22;
    cycle("bp_b");
    check1("bp_full_in_ready", bus.in_ready, 1'b0);
    checkw("bp_head", bus.out_result, 32'h11);
    bus.in_valid = 1'b0; rand_data();
    cycle("bp_hold");
    checkw("bp_hold_head", bus.out_result, 32'h11);
    bus.out_ready = 1'b1;
    cycle("bp_pop1");
    checkw("bp_second", bus.out_result, 32'h22);
    check1("bp_ready_after_pop", bus.in_ready, 1'b1);
    cycle("bp_pop2");
    check1("bp_empty", bus.out_valid, 1'b0);

    // continuous push+pop streaming
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rand_data();
      bus.alu_op = legal_ops[$urandom_range(0, 4)];
      cycle("stream");
    end
    bus.in_valid = 1'b0;
    cycle("stream_drain");

    // flush while full with a push request pending
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    rand_data(); cycle("flush_fill_a");
    rand_data(); cycle("flush_fill_b");
    bus.flush = 1'b1; rand_data();
    cycle("flush_two");
    check1("flush_two_valid", bus.out_valid, 1'b0);
    check1("flush_two_ready", bus.in_ready, 1'b1);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    cycle("flush_two_after");
    // flush in ONE drops a concurrent accepted push
    bus.in_valid = 1'b1; rand_data();
    cycle("flush_one_fill");
    bus.flush = 1'b1; rand_data();
    cycle("flush_one");
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    cycle("flush_one_after");

    // reserved opcode
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.alu_op = 3'd3; rand_data();
    cycle("reserved");
    checkw("reserved_result", bus.out_result, 32'h0);
    check1("reserved_zero", bus.out_zero, 1'b1);
    check1("reserved_illegal", bus.out_illegal, 1'b1);
    bus.in_valid = 1'b0;
    cycle("reserved_drain");

    // random traffic with all opcodes and occasional flush
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 19) == 0);
      bus.alu_op    = 3'($urandom());
      rand_data();
      cycle("rand");
    end
    bus.flush = 1'b0;

    // asynchronous reset in the middle of a full buffer
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.alu_op = 3'd1;
    rand_data(); cycle("mid_fill_a");
    rand_data(); cycle("mid_fill_b");
    #2 rst_n = 1'b0;
    model_q.delete();
    model_rdy_en = 1'b0;
    #1 check_all("mid_async_reset");
    check1("mid_reset_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    cycle("mid_in_reset");
    rst_n = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    cycle("mid_release");
    check1("mid_no_stale", bus.out_valid, 1'b0);
    bus.in_valid = 1'b1; rand_data();
    cycle("mid_push");
    bus.in_valid = 1'b0;
    cycle("mid_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width of all result/operand ports.
REQ-002 SHALL have parameter DEPTH, default 2, fixed buffer entries (only 2 supported).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream ALU outputs valid this cycle.
REQ-006 in_ready  output  1  stage can accept an entry.
REQ-007 alu_op  input  3  select: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; others reserved.
REQ-008 resultofand  input  WIDTH  bitwise AND from the AND unit.
REQ-009 resultofor  input  WIDTH  bitwise OR from the OR unit.
REQ-010 resultofadd  input  WIDTH  adder sum.
REQ-011 resultofsub  input  WIDTH  subtractor difference.
REQ-012 dataout1, dataout2  input  WIDTH each  register-file operands, used for SLT only.
REQ-013 dest_reg  input  5  destination register number carried with result.
REQ-014 flush  input  1  synchronous discard of all buffered entries.
REQ-015 out_valid  output  1  head entry present.
REQ-016 out_ready  input  1  downstream accepts head entry.
REQ-017 out_result  output  WIDTH  selected result of head entry.
REQ-018 out_zero  output  1  1 when out_result == 0.
REQ-019 out_dest  output  5  dest_reg of head entry.
REQ-020 out_illegal  output  1  head entry was captured with a reserved alu_op.

Function
REQ-021 Result select (combinational, at capture): AND/OR/ADD/SUB pass matching input; SLT gives {WIDTH-1 zeros, signed(dataout1) < signed(dataout2)}; reserved codes give 0 with illegal=1.
REQ-022 Push when in_valid && in_ready; pop when out_valid && out_ready; both on the same edge.
REQ-023 State count in {EMPTY=0, ONE=1, TWO=2}; in_ready = (count != TWO); out_valid = (count != EMPTY); both derived from registered state only, no combinational path from out_ready to in_ready.
REQ-024 Transitions: EMPTY+push->ONE; ONE+push only->TWO; ONE+pop only->EMPTY; ONE+push+pop->ONE (new entry becomes head next cycle); TWO+pop->ONE (second entry becomes head); no push possible in TWO.
REQ-025 Order SHALL be strict FIFO; latency in_valid accept to out_valid = 1 cycle when EMPTY.
REQ-026 While out_valid && !out_ready, out_result/out_zero/out_dest/out_illegal SHALL hold stable.
REQ-027 out_zero and out_illegal SHALL be stored per entry, not recomputed from live inputs.
REQ-028 flush SHALL set count to EMPTY on the next edge regardless of push/pop that cycle; a concurrent push is dropped.
REQ-029 When out_valid=0, out_result, out_dest, out_zero, out_illegal SHALL be 0.
REQ-030 ADD/SUB overflow SHALL not be detected; inputs pass through unmodified at WIDTH bits.

Reset
REQ-031 rst_n low SHALL immediately force count=EMPTY, out_valid=0, in_ready=0 while asserted, all data outputs 0.
REQ-032 in_ready SHALL go 1 on the first clk edge after rst_n deasserts; reset mid-transfer discards all entries.

Verification
REQ-033 AND: alu_op=000, resultofand=0x0000_00F0, dest_reg=5, out_ready=1 -> next cycle out_valid=1, out_result=0x0000_00F0, out_dest=5, out_zero=0.
REQ-034 SLT: dataout1=0xFFFF_FFFF, dataout2=0x0000_0001, alu_op=111 -> out_result=0x0000_0001; swapped -> 0x0000_0000, out_zero=1.
REQ-035 Backpressure: out_ready=0, push A=0x11, B=0x22 -> in_ready=0 after 2nd push, out_result holds 0x11; out_ready=1 -> 0x11 then 0x22 on consecutive cycles, in_ready=1 after first pop.
REQ-036 Simultaneous push+pop in ONE with continuous in_valid/out_ready -> one result per cycle, count stays ONE, no loss.
REQ-037 flush with TWO entries and in_valid=1 -> next cycle out_valid=0, in_ready=1, pushed entry absent.
REQ-038 Reserved alu_op=011 -> out_result=0, out_zero=1, out_illegal=1; rst_n pulse low mid-stream -> out_valid=0 immediately, no stale entry afterwards.
